// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side UART transmitter.
package fifo_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LATCH  = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } tx_state_t;

    localparam logic TX_IDLE_LEVEL = 1'b1;
    localparam logic START_LEVEL   = 1'b0;
    localparam int   RD_LATENCY    = 1;

    // Parity over a zero-extended data word; odd selects odd parity.
    function automatic logic calc_parity(input logic [63:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high, held at 0 otherwise.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_read,
    input  logic rst,
    input  logic run,
    output logic bit_tick,
    output logic bit_tick_next
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // run never drops one cycle before a bit boundary, so the tick can be pre-registered.
    assign bit_tick_next = run && (cnt_r == PRE);
    assign bit_tick      = tick_r;

    // Baud count register, cleared whenever the transmitter is not shifting.
    always_ff @(posedge clk_read or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (!run || (cnt_r == LAST)) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Registered bit-boundary strobe, high in the last cycle of each bit.
    always_ff @(posedge clk_read or posedge rst) begin
        if (rst) begin
            tick_r <= 1'b0;
        end else begin
            tick_r <= bit_tick_next;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the async FIFO read port and serialises them as UART frames.
module fifo_uart_tx
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk_read,
    input  logic                  rst,
    input  logic                  Tx_enable,
    input  logic                  Empty,
    input  logic [DATA_WIDTH-1:0] DataOut,
    output logic                  Read_enable,
    output logic                  Tx,
    output logic                  Busy,
    output logic                  Frame_done
);

    localparam int            BW        = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    tx_state_t             state_r, state_next_s;
    logic [DATA_WIDTH-1:0] shift_r, shift_next_s;
    logic [BW-1:0]         bit_cnt_r, bit_cnt_next_s;
    logic                  parity_r, parity_next_s;
    logic                  run_s, bit_tick_s, bit_tick_next_s, fetch_ok_s;
    logic                  tx_next_s, re_next_s, busy_next_s, fd_next_s;
    logic                  tx_r, re_r, busy_r, fd_r;

    assign fetch_ok_s = Tx_enable && !Empty;
    assign run_s      = (state_r == START) || (state_r == DATA) ||
                        (state_r == PARITY) || (state_r == STOP);

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk_read      (clk_read),
        .rst           (rst),
        .run           (run_s),
        .bit_tick      (bit_tick_s),
        .bit_tick_next (bit_tick_next_s)
    );

    // Next-state, shift register and bit counter update.
    always_comb begin
        state_next_s   = state_r;
        shift_next_s   = shift_r;
        bit_cnt_next_s = bit_cnt_r;
        parity_next_s  = parity_r;
        case (state_r)
            IDLE: begin
                if (fetch_ok_s) begin
                    state_next_s = FETCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FETCH: begin
                state_next_s = LATCH;
            end
            LATCH: begin
                shift_next_s   = DataOut;
                parity_next_s  = calc_parity(64'(DataOut), PARITY_ODD != 0);
                bit_cnt_next_s = {BW{1'b0}};
                state_next_s   = START;
            end
            START: begin
                if (bit_tick_s) begin
                    state_next_s = DATA;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (bit_tick_s) begin
                    shift_next_s = {1'b0, shift_r[DATA_WIDTH-1:1]};
                    if (bit_cnt_r == LAST_DATA) begin
                        bit_cnt_next_s = {BW{1'b0}};
                        state_next_s   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_next_s = bit_cnt_r + BW'(1);
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
            PARITY: begin
                if (bit_tick_s) begin
                    state_next_s = STOP;
                end else begin
                    state_next_s = PARITY;
                end
            end
            STOP: begin
                if (bit_tick_s) begin
                    if (bit_cnt_r == LAST_STOP) begin
                        bit_cnt_next_s = {BW{1'b0}};
                        state_next_s   = fetch_ok_s ? FETCH : IDLE;
                    end else begin
                        bit_cnt_next_s = bit_cnt_r + BW'(1);
                    end
                end else begin
                    state_next_s = STOP;
                end
            end
            default: begin
                state_next_s   = IDLE;
                shift_next_s   = {DATA_WIDTH{1'b0}};
                bit_cnt_next_s = {BW{1'b0}};
                parity_next_s  = 1'b0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the flops line up with state_r.
    always_comb begin
        tx_next_s   = TX_IDLE_LEVEL;
        re_next_s   = (state_next_s == FETCH);
        busy_next_s = (state_next_s != IDLE);
        fd_next_s   = (state_next_s == STOP) && (bit_cnt_next_s == LAST_STOP) && bit_tick_next_s;
        case (state_next_s)
            START:   tx_next_s = START_LEVEL;
            DATA:    tx_next_s = shift_next_s[0];
            PARITY:  tx_next_s = parity_next_s;
            default: tx_next_s = TX_IDLE_LEVEL;
        endcase
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk_read or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            shift_r   <= {DATA_WIDTH{1'b0}};
            bit_cnt_r <= {BW{1'b0}};
            parity_r  <= 1'b0;
            tx_r      <= TX_IDLE_LEVEL;
            re_r      <= 1'b0;
            busy_r    <= 1'b0;
            fd_r      <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            shift_r   <= shift_next_s;
            bit_cnt_r <= bit_cnt_next_s;
            parity_r  <= parity_next_s;
            tx_r      <= tx_next_s;
            re_r      <= re_next_s;
            busy_r    <= busy_next_s;
            fd_r      <= fd_next_s;
        end
    end

    assign Tx          = tx_r;
    assign Read_enable = re_r;
    assign Busy        = busy_r;
    assign Frame_done  = fd_r;

endmodule
